// File: rtl/ecc_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ecc_apb_ctrl_if
// APB bus bundle between a bus master and the ECC control block.
//   PADDR    master->slave  register address (word index in bits [4:2])
//   PWDATA   master->slave  write data
//   PENABLE  master->slave  access phase
//   PSEL     master->slave  slave select
//   PWRITE   master->slave  1 = write, 0 = read
//   PRDATA   slave->master  read data, valid during the access phase
// ---------------------------------------------------------------------------
interface ecc_apb_ctrl_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PENABLE;
    logic                       PSEL;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        output PADDR, PWDATA, PENABLE, PSEL, PWRITE,
        input  PRDATA
    );

    modport slave (
        input  PADDR, PWDATA, PENABLE, PSEL, PWRITE,
        output PRDATA
    );
endinterface

// File: rtl/ecc_apb_ctrl.sv
// ---------------------------------------------------------------------------
// ecc_apb_ctrl
// APB slave that holds the ECC operation registers, launches one core
// operation per CTRL write, waits for the core (with a timeout) and exposes
// the result and sticky status flags.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   apb             APB slave bundle (PADDR/PWDATA/PENABLE/PSEL/PWRITE/PRDATA)
//   core_start      one-cycle start pulse to the core
//   core_mode       0=encode, 1=decode, 2=full
//   core_width      0=8b, 1=16b, 2=32b
//   core_data       DATA_IN masked to the selected width
//   core_noise      NOISE masked to the selected width
//   core_done       core completion pulse (only honoured while waiting)
//   core_result     core result, valid with core_done
//   core_errors     core error count, valid with core_done
//   data_out        last result (0 after a timeout)
//   operation_done  one-cycle pulse per completed or timed-out operation
//   num_of_errors   last error count (0 after a timeout)
//
// Register map (index = PADDR[4:2])
//   0 CTRL (W)  1 DATA_IN (W/R)  2 CODEWORD_WIDTH (W/R)  3 NOISE (W/R)
//   4 STATUS (RO) = {timeout, busy_err, done, num_of_errors[1:0]}
//   5 RESULT (RO)  6,7 unmapped (read 0)
// ---------------------------------------------------------------------------
module ecc_apb_ctrl #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_apb_ctrl_if.slave         apb,
    output logic                  core_start,
    output logic [1:0]            core_mode,
    output logic [1:0]            core_width,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic [DATA_WIDTH-1:0] core_noise,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_result,
    input  logic [1:0]            core_errors,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_DATA_IN = 3'd1;
    localparam logic [2:0] REG_WIDTH   = 3'd2;
    localparam logic [2:0] REG_NOISE   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_RESULT  = 3'd5;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    logic [AMBA_WORD-1:0] data_in_reg;
    logic [AMBA_WORD-1:0] noise_reg;
    logic [1:0]           width_reg;
    logic                 done_flag_reg;
    logic                 busy_err_reg;
    logic                 timeout_reg;

    logic [AMBA_WORD-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] width_mask;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0] reg_idx;
    logic       wr_access, rd_setup, rd_access;
    logic       ctrl_wr, launch, busy_hit, status_rd;
    logic       finish_ok, finish_to;
    logic       unused_paddr;

    assign reg_idx   = apb.PADDR[4:2];
    assign wr_access = apb.PSEL &  apb.PENABLE &  apb.PWRITE;
    assign rd_setup  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign rd_access = apb.PSEL &  apb.PENABLE & ~apb.PWRITE;

    assign ctrl_wr   = wr_access && (reg_idx == REG_CTRL);
    assign launch    = ctrl_wr && (state_reg == ST_IDLE) && (apb.PWDATA[1:0] != 2'b11);
    assign busy_hit  = ctrl_wr && (state_reg != ST_IDLE);
    assign status_rd = rd_access && (reg_idx == REG_STATUS);

    // core_done wins over a timeout landing in the same cycle
    assign finish_ok = (state_reg == ST_WAIT) && core_done;
    assign finish_to = (state_reg == ST_WAIT) && !core_done &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    assign unused_paddr = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

    // Width codes whose bit count exceeds the core's data path are rejected.
    function automatic logic width_ok(input logic [1:0] code);
        case (code)
            2'd0:    return (DATA_WIDTH >= 8);
            2'd1:    return (DATA_WIDTH >= 16);
            2'd2:    return (DATA_WIDTH >= 32);
            default: return 1'b0;
        endcase
    endfunction

    // Per-bit keep mask for the currently programmed width.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
        assign width_mask[gi] = (gi < 8) ||
                                ((gi < 16) && (width_reg != 2'd0)) ||
                                (width_reg == 2'd2);
    end

    assign core_start     = (state_reg == ST_START);
    assign operation_done = (state_reg == ST_DONE);

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Counter holds the 1-based index of the current WAIT cycle,
                // so the abort decision is made in WAIT cycle TIMEOUT_CYCLES.
                state_next = ST_WAIT;
                cnt_next   = CNT_W'(1);
            end
            ST_WAIT: begin
                if (finish_ok || finish_to) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux (sampled into PRDATA during the setup phase)
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_DATA_IN: rd_mux = data_in_reg;
            REG_WIDTH:   rd_mux = AMBA_WORD'(width_reg);
            REG_NOISE:   rd_mux = noise_reg;
            REG_STATUS:  rd_mux = AMBA_WORD'({timeout_reg, busy_err_reg,
                                              done_flag_reg, num_of_errors});
            REG_RESULT:  rd_mux = AMBA_WORD'(data_out);
            default:     rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State and register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            data_in_reg   <= '0;
            noise_reg     <= '0;
            width_reg     <= 2'd0;
            done_flag_reg <= 1'b0;
            busy_err_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            apb.PRDATA    <= '0;
            core_mode     <= 2'd0;
            core_width    <= 2'd0;
            core_data     <= '0;
            core_noise    <= '0;
            data_out      <= '0;
            num_of_errors <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (rd_setup) begin
                apb.PRDATA <= rd_mux;
            end

            if (wr_access) begin
                case (reg_idx)
                    REG_DATA_IN: data_in_reg <= apb.PWDATA;
                    REG_NOISE:   noise_reg   <= apb.PWDATA;
                    REG_WIDTH: begin
                        if (width_ok(apb.PWDATA[1:0])) begin
                            width_reg <= apb.PWDATA[1:0];
                        end
                    end
                    default: ;
                endcase
            end

            // Operands are frozen at launch so later register writes only
            // affect the next operation.
            if (launch) begin
                core_mode  <= apb.PWDATA[1:0];
                core_width <= width_reg;
                core_data  <= data_in_reg[DATA_WIDTH-1:0] & width_mask;
                core_noise <= noise_reg[DATA_WIDTH-1:0] & width_mask;
            end

            if (finish_ok) begin
                data_out      <= core_result;
                num_of_errors <= core_errors;
            end else if (finish_to) begin
                data_out      <= '0;
                num_of_errors <= 2'd0;
            end

            // Sticky flags: a set in the same cycle as a STATUS read wins.
            if (finish_ok || finish_to) begin
                done_flag_reg <= 1'b1;
            end else if (status_rd) begin
                done_flag_reg <= 1'b0;
            end

            if (finish_to) begin
                timeout_reg <= 1'b1;
            end else if (status_rd) begin
                timeout_reg <= 1'b0;
            end

            if (busy_hit) begin
                busy_err_reg <= 1'b1;
            end else if (status_rd) begin
                busy_err_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ecc_apb_ctrl
// Directed bench for ecc_apb_ctrl: the core is emulated by driving
// core_done/core_result/core_errors by hand.
// ---------------------------------------------------------------------------
module tb_ecc_apb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [1:0]  core_width;
    logic [31:0] core_data;
    logic [31:0] core_noise;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;
    logic [1:0]  core_errors = 2'd0;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    ecc_apb_ctrl_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) apb ();

    ecc_apb_ctrl #(
        .AMBA_ADDR_WIDTH(20),
        .AMBA_WORD(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .apb(apb),
        .core_start(core_start),
        .core_mode(core_mode),
        .core_width(core_width),
        .core_data(core_data),
        .core_noise(core_noise),
        .core_done(core_done),
        .core_result(core_result),
        .core_errors(core_errors),
        .data_out(data_out),
        .operation_done(operation_done),
        .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start)     start_cnt <= start_cnt + 1;
        if (operation_done) done_cnt  <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = addr; apb.PWDATA = data;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = addr;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(negedge clk);
        data = apb.PRDATA;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    // Called just after a posedge while the DUT is in WAIT; returns at the
    // negedge of the DONE cycle.
    task automatic core_complete(input logic [31:0] res, input logic [1:0] errs);
        core_done = 1'b1; core_result = res; core_errors = errs;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int s0;
        int d0;
        int found;

        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_prdata", apb.PRDATA, 32'h0);
        check("rst_core_start", {31'b0, core_start}, 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_op_done", {31'b0, operation_done}, 32'h0);
        check("rst_core_data", core_data, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 8-bit encode
        apb_write(20'h04, 32'h1234_56A5);
        apb_write(20'h08, 32'h0);
        apb_read(20'h04, rd);
        check("data_in_readback", rd, 32'h1234_56A5);
        apb_write(20'h00, 32'h0);
        @(negedge clk);
        check("t2_start", {31'b0, core_start}, 32'h1);
        check("t2_core_data", core_data, 32'h0000_00A5);
        check("t2_core_mode", {30'b0, core_mode}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_start_one_clk", {31'b0, core_start}, 32'h0);
        core_complete(32'h3C, 2'd0);
        check("t2_op_done", {31'b0, operation_done}, 32'h1);
        check("t2_data_out", data_out, 32'h3C);
        @(negedge clk);
        check("t2_op_done_pulse", {31'b0, operation_done}, 32'h0);
        apb_read(20'h14, rd);
        check("t2_result_reg", rd, 32'h3C);

        // Decode with a single error, STATUS read-to-clear
        apb_write(20'h00, 32'h1);
        @(negedge clk);
        check("t3_core_mode", {30'b0, core_mode}, 32'h1);
        @(posedge clk); #1;
        core_complete(32'h55, 2'd1);
        check("t3_num_errors", {30'b0, num_of_errors}, 32'h1);
        apb_read(20'h10, rd);
        check("t3_status_first", rd, 32'h05);
        apb_read(20'h10, rd);
        check("t3_status_reread", rd, 32'h01);

        // CTRL write while busy, 32-bit full mode
        apb_write(20'h08, 32'h2);
        s0 = start_cnt;
        apb_write(20'h00, 32'h2);
        @(negedge clk);
        check("t4_core_data", core_data, 32'h1234_56A5);
        check("t4_core_width", {30'b0, core_width}, 32'h2);
        @(posedge clk); #1;
        apb_write(20'h00, 32'h0);
        core_complete(32'h0F, 2'd2);
        check("t4_op_done", {31'b0, operation_done}, 32'h1);
        check("t4_start_count", start_cnt - s0, 32'd1);
        apb_read(20'h10, rd);
        check("t4_status_busy", rd, 32'h0E);
        apb_read(20'h10, rd);
        check("t4_status_cleared", rd, 32'h02);

        // core_done while IDLE is ignored
        d0 = done_cnt;
        @(posedge clk); #1;
        core_done = 1'b1; core_result = 32'hFF; core_errors = 2'd1;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done_data_out", data_out, 32'h0F);
        check("idle_done_errors", {30'b0, num_of_errors}, 32'h2);
        check("idle_done_no_pulse", done_cnt - d0, 32'd0);

        // Timeout with 16-bit width
        apb_write(20'h08, 32'h1);
        apb_write(20'h00, 32'h0);
        @(negedge clk);
        check("t5_core_data", core_data, 32'h0000_56A5);
        check("t5_core_width", {30'b0, core_width}, 32'h1);
        found = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (operation_done) begin
                found = k;
                break;
            end
        end
        check("t5_timeout_latency", found, 32'd65);
        check("t5_data_out", data_out, 32'h0);
        check("t5_num_errors", {30'b0, num_of_errors}, 32'h0);
        apb_read(20'h10, rd);
        check("t5_status", rd, 32'h14);

        // Illegal width, unmapped register, upper address bits, CTRL=3
        apb_write(20'h08, 32'h3);
        apb_read(20'h08, rd);
        check("t6_width_kept", rd, 32'h1);
        apb_read(20'h1C, rd);
        check("t6_unmapped_read", rd, 32'h0);
        apb_read(20'h80004, rd);
        check("t6_addr_alias", rd, 32'h1234_56A5);
        s0 = start_cnt;
        apb_write(20'h00, 32'h3);
        repeat (3) @(negedge clk);
        check("t6_ctrl3_no_start", start_cnt - s0, 32'd0);
        apb_read(20'h10, rd);
        check("t6_ctrl3_status", rd, 32'h0);

        // Reset in the middle of an operation
        apb_write(20'h00, 32'h0);
        @(posedge clk); #1;
        core_complete(32'h99, 2'd1);
        apb_write(20'h00, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("t1_core_start", {31'b0, core_start}, 32'h0);
        check("t1_op_done", {31'b0, operation_done}, 32'h0);
        check("t1_data_out", data_out, 32'h0);
        check("t1_num_errors", {30'b0, num_of_errors}, 32'h0);
        check("t1_core_data", core_data, 32'h0);
        check("t1_core_mode", {30'b0, core_mode}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_cnt;
        core_done = 1'b1; core_result = 32'h77;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (6) @(negedge clk);
        check("t1_no_op_done", done_cnt - d0, 32'd0);
        check("t1_data_out_after", data_out, 32'h0);
        apb_read(20'h10, rd);
        check("t1_status", rd, 32'h0);
        apb_read(20'h04, rd);
        check("t1_data_in_cleared", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
